// File: rtl/palindrome_pkg.sv
// Shared definitions for the palindrome arbiter slice.
//   state_e            : controller states (IDLE, CHECK, RESULT)
//   DATA_WIDTH_DEFAULT : default operand width
//   id_width()         : width of a requester index, never less than 1
package palindrome_pkg;

    localparam int DATA_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        RESULT = 2'd2
    } state_e;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/palindrome_core.sv
// Pure combinational palindrome checker.
//   din  : operand
//   dout : 1 when the bit-reversal of din equals din (leading zeros count).
//          The middle bit of an odd width is never compared, so a 1-bit
//          operand always reports 1.
module palindrome_core #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  dout
);

    always_comb begin
        dout = 1'b1;
        for (int i = 0; i < DATA_WIDTH / 2; i++) begin
            if (din[i] != din[DATA_WIDTH-1-i]) begin
                dout = 1'b0;
            end
        end
    end

endmodule

// File: rtl/palindrome_arbiter.sv
// Shares one palindrome checker among NUM_REQ requesters.
//   clk, resetn          : clock, asynchronous active-low reset
//   req_valid/req_data   : per-requester operand channel (requester i at
//                          bits [i*DATA_WIDTH +: DATA_WIDTH])
//   req_ready            : one-hot (or zero) accept towards the winner
//   res_valid/res_ready  : result channel, res_id = requester, res_pal = result
//   busy                 : controller not idle
//   pal_count            : delivered results with res_pal=1, saturating
//
// state  | meaning
// IDLE   | no result pending, accept a new request
// CHECK  | operand registered, checker output captured at the next edge
// RESULT | result presented; on handshake a new request may be accepted
module palindrome_arbiter
    import palindrome_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int CNT_WIDTH  = 16,
    localparam int ID_W      = id_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [ID_W-1:0]               res_id,
    output logic                          res_pal,
    output logic                          busy,
    output logic [CNT_WIDTH-1:0]          pal_count
);

    state_e                state_q, state_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] operand_q, operand_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [ID_W-1:0]       res_id_q, res_id_d;
    logic                  res_pal_q, res_pal_d;
    logic [CNT_WIDTH-1:0]  pal_count_q, pal_count_d;

    logic [ID_W:0]         pick;
    logic                  win_vld;
    logic [ID_W-1:0]       win_id;
    logic [DATA_WIDTH-1:0] win_data;
    logic                  can_accept;
    logic                  accept;
    logic                  res_hs;
    logic                  core_pal;

    // Returns {found, index}. Scanning from the farthest offset down lets the
    // nearest valid requester (starting at p) overwrite earlier hits.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                              input logic [ID_W-1:0]    p);
        logic [ID_W:0]   r;
        logic [ID_W-1:0] idx;
        r = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = ID_W'((int'(p) + i) % NUM_REQ);
            if (v[idx]) begin
                r = {1'b1, idx};
            end
        end
        return r;
    endfunction

    assign pick    = rr_pick(req_valid, ptr_q);
    assign win_vld = pick[ID_W];
    assign win_id  = pick[ID_W-1:0];

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_id == ID_W'(i)) begin
                win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // resetn gates acceptance so nothing is granted while reset is held.
    assign can_accept = resetn &&
                        ((state_q == IDLE) || ((state_q == RESULT) && res_ready));
    assign accept     = can_accept && win_vld;
    assign res_hs     = (state_q == RESULT) && res_ready;

    palindrome_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .din  (operand_q),
        .dout (core_pal)
    );

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CHECK;
            CHECK:   state_d = RESULT;
            RESULT:  if (res_ready) state_d = accept ? CHECK : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = accept && (win_id == ID_W'(i));
        end
        res_valid = (state_q == RESULT);
        busy      = (state_q != IDLE);
    end

    assign res_id    = res_id_q;
    assign res_pal   = res_pal_q;
    assign pal_count = pal_count_q;

    // Datapath next values
    always_comb begin
        ptr_d       = ptr_q;
        operand_d   = operand_q;
        id_d        = id_q;
        res_id_d    = res_id_q;
        res_pal_d   = res_pal_q;
        pal_count_d = pal_count_q;
        if (accept) begin
            operand_d = win_data;
            id_d      = win_id;
            ptr_d     = ID_W'((int'(win_id) + 1) % NUM_REQ);
        end
        if (state_q == CHECK) begin
            res_pal_d = core_pal;
            res_id_d  = id_q;
        end
        if (res_hs && res_pal_q && (pal_count_q != '1)) begin
            pal_count_d = pal_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_q       <= '0;
            operand_q   <= '0;
            id_q        <= '0;
            res_id_q    <= '0;
            res_pal_q   <= 1'b0;
            pal_count_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            operand_q   <= operand_d;
            id_q        <= id_d;
            res_id_q    <= res_id_d;
            res_pal_q   <= res_pal_d;
            pal_count_q <= pal_count_d;
        end
    end

endmodule

// File: tb/tb_palindrome_arbiter.sv
module tb_palindrome_arbiter;

    logic        clk;
    logic        resetn;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_id;
    logic        res_pal;
    logic        busy;
    logic [15:0] pal_count;

    int checks = 0;
    int errors = 0;

    palindrome_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .CNT_WIDTH  (16)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_pal   (res_pal),
        .busy      (busy),
        .pal_count (pal_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [3:0] pal_exp;
    int         gexp[4];

    initial begin
        pal_exp = 4'b1011;
        gexp    = '{2, 0, 2, 0};

        // 1. reset with every requester valid
        resetn    = 1'b0;
        req_valid = 4'hF;
        req_data  = 32'hFF01_1881;
        res_ready = 1'b0;
        #12;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_id",    32'(res_id), 0);
        chk("rst_res_pal",   32'(res_pal), 0);
        chk("rst_pal_count", 32'(pal_count), 0);
        chk("rst_busy",      32'(busy), 0);

        // 2. single requests: A5 (palindrome) then A4 (not)
        @(posedge clk); #2;
        resetn    = 1'b1;
        req_valid = 4'h0;
        @(posedge clk); #2;
        req_valid = 4'b0001;
        req_data  = 32'h0000_00A5;
        res_ready = 1'b1;
        #1;
        chk("s1_req_ready", 32'(req_ready), 32'b0001);
        @(posedge clk); #2;
        req_valid = 4'h0;
        chk("s1_busy_check", 32'(busy), 1);
        chk("s1_valid_check", 32'(res_valid), 0);
        @(posedge clk); #2;
        chk("s1_res_valid", 32'(res_valid), 1);
        chk("s1_res_id",    32'(res_id), 0);
        chk("s1_res_pal",   32'(res_pal), 1);
        @(posedge clk); #2;
        chk("s1_pal_count", 32'(pal_count), 1);
        chk("s1_idle_valid", 32'(res_valid), 0);
        req_valid = 4'b0001;
        req_data  = 32'h0000_00A4;
        #1;
        chk("s2_req_ready", 32'(req_ready), 32'b0001);
        @(posedge clk); #2;
        req_valid = 4'h0;
        @(posedge clk); #2;
        chk("s2_res_valid", 32'(res_valid), 1);
        chk("s2_res_pal",   32'(res_pal), 0);
        @(posedge clk); #2;
        chk("s2_pal_count", 32'(pal_count), 1);
        chk("s2_busy",      32'(busy), 0);

        // 3. all four valid from reset, back-to-back results
        resetn = 1'b0;
        #2;
        resetn = 1'b1;
        @(posedge clk); #2;
        req_valid = 4'hF;
        req_data  = 32'hFF01_1881;
        res_ready = 1'b1;
        #1;
        chk("rr_grant0", 32'(req_ready), 32'b0001);
        chk("rr_valid0", 32'(res_valid), 0);
        for (int k = 1; k < 4; k++) begin
            @(posedge clk); #2;
            chk("rr_check_ready", 32'(req_ready), 0);
            chk("rr_check_valid", 32'(res_valid), 0);
            @(posedge clk); #2;
            chk("rr_res_valid", 32'(res_valid), 1);
            chk("rr_res_id",    32'(res_id), 32'(k - 1));
            chk("rr_res_pal",   32'(res_pal), 32'(pal_exp[k-1]));
            chk("rr_grant",     32'(req_ready), 32'(1 << k));
        end
        @(posedge clk); #2;
        @(posedge clk); #2;
        chk("rr_res_valid3", 32'(res_valid), 1);
        chk("rr_res_id3",    32'(res_id), 3);
        chk("rr_res_pal3",   32'(res_pal), 1);
        req_valid = 4'h0;
        #1;
        chk("rr_no_grant", 32'(req_ready), 0);
        @(posedge clk); #2;
        chk("rr_pal_count", 32'(pal_count), 3);
        chk("rr_idle_valid", 32'(res_valid), 0);

        // 4. backpressure, then handshake with same-edge acceptance
        req_valid = 4'b0001;
        req_data  = 32'h0000_0100;
        res_ready = 1'b0;
        @(posedge clk); #2;
        req_valid = 4'b0010;
        @(posedge clk); #2;
        for (int c = 0; c < 5; c++) begin
            chk("bp_res_valid", 32'(res_valid), 1);
            chk("bp_res_id",    32'(res_id), 0);
            chk("bp_res_pal",   32'(res_pal), 1);
            chk("bp_req_ready", 32'(req_ready), 0);
            @(posedge clk); #2;
        end
        res_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'b0010);
        @(posedge clk); #2;
        chk("bp_pal_count", 32'(pal_count), 4);
        chk("bp_check_valid", 32'(res_valid), 0);
        @(posedge clk); #2;
        chk("bp_res_valid1", 32'(res_valid), 1);
        chk("bp_res_id1",    32'(res_id), 1);
        chk("bp_res_pal1",   32'(res_pal), 0);

        // 5. fairness: grant req0 alone to leave ptr=1, then hold req0+req2
        req_valid = 4'b0001;
        #1;
        chk("fair_setup_grant", 32'(req_ready), 32'b0001);
        @(posedge clk); #2;
        req_valid = 4'b0101;
        @(posedge clk); #2;
        for (int j = 0; j < 4; j++) begin
            chk("fair_grant", 32'(req_ready), 32'(1 << gexp[j]));
            if (j > 0) begin
                chk("fair_res_id", 32'(res_id), 32'(gexp[j-1]));
            end
            if (j < 3) begin
                @(posedge clk); #2;
                @(posedge clk); #2;
            end
        end
        req_valid = 4'h0;
        @(posedge clk); #2;
        chk("fair_idle", 32'(busy), 0);

        // 6. async reset while CHECK holds operand 3C
        req_valid = 4'b0001;
        req_data  = 32'h0000_003C;
        @(posedge clk); #2;
        req_valid = 4'h0;
        chk("ar_busy_check", 32'(busy), 1);
        #1;
        resetn = 1'b0;
        #1;
        chk("ar_busy",      32'(busy), 0);
        chk("ar_res_valid", 32'(res_valid), 0);
        chk("ar_res_id",    32'(res_id), 0);
        chk("ar_res_pal",   32'(res_pal), 0);
        chk("ar_pal_count", 32'(pal_count), 0);
        @(posedge clk); #2;
        resetn = 1'b1;
        @(posedge clk); #2;
        chk("ar_no_result1", 32'(res_valid), 0);
        chk("ar_idle",       32'(busy), 0);
        @(posedge clk); #2;
        chk("ar_no_result2", 32'(res_valid), 0);
        req_valid = 4'b1010;
        #1;
        chk("ar_ptr_zero", 32'(req_ready), 32'b0010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/palindrome_arbiter.md
Name: palindrome_arbiter

Overview:
Shares one combinational palindrome checker among NUM_REQ requesters. Each requester presents a DATA_WIDTH word on a valid/ready interface. A round-robin arbiter grants one request at a time, and the operand is registered into the checker. The result is returned on a single valid/ready result channel tagged with the requester ID, and a saturating counter tracks delivered palindrome results.

Parameters:
NUM_REQ, 4, number of requesters (>=1)
DATA_WIDTH, 32, operand width in bits (>=1)
CNT_WIDTH, 16, width of palindrome result counter

Ports:
clk  input  1  clock, all state on rising edge
resetn  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester request valid
req_data  input  NUM_REQ*DATA_WIDTH  operands; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  output  NUM_REQ  one-hot (or zero) grant/accept
res_valid  output  1  result valid
res_ready  input  1  downstream accepts result
res_id  output  ID_W  requester index of result; ID_W = max(1, $clog2(NUM_REQ))
res_pal  output  1  1 if operand bit-reversal equals operand (leading zeros count)
busy  output  1  state != IDLE
pal_count  output  CNT_WIDTH  number of delivered results with res_pal=1, saturating

Behaviour:
- Reset (async, resetn=0): state=IDLE, rr pointer=0, operand reg=0, res_valid=0, res_id=0, res_pal=0, pal_count=0. req_ready=0 while in reset. An in-flight request is discarded; no result is produced for it.
- Arbiter:
  - Round-robin search begins at pointer ptr and wraps modulo NUM_REQ; first requester with valid high wins.
  - After a grant to g: ptr <= (g+1) mod NUM_REQ.
  - NUM_REQ=1: ptr stays 0.
- req_ready[g] is combinational and asserts only for the winner, and only when the block can accept (see states). A request is accepted when req_valid[g] && req_ready[g].
- States:
  - IDLE: accept if any req_valid. Capture operand, id <= g, go to CHECK. Otherwise stay.
  - CHECK: res_pal <= palindrome(operand), res_id <= id, res_valid <= 1, go to RESULT. No req_ready in this state.
  - RESULT: res_valid=1; res_id and res_pal are held stable.
    - res_ready=0: stay, no req_ready.
    - res_ready=1: result is delivered. If any req_valid, accept the new request in the same cycle and go to CHECK; else go to IDLE and res_valid <= 0.
- Latency: acceptance at edge T gives res_valid at T+2. Sustained throughput is 1 result per 2 cycles.
- pal_count increments on each result handshake with res_pal=1 and saturates at all-ones (no wrap).
- Palindrome rule:
  - Compare bit i with bit DATA_WIDTH-1-i for i < DATA_WIDTH/2.
  - For odd widths the middle bit is ignored.
  - DATA_WIDTH=1 always gives 1.
- Requester data and valid are sampled only on the accepting edge. Later changes do not affect the in-flight result.

Decomposition:
- Package palindrome_pkg:
  - state enum {IDLE, CHECK, RESULT}
  - ID width helper function
  - DATA_WIDTH default constant
- Sub-module palindrome_core, parameter DATA_WIDTH, input din, output dout: pure combinational checker, instantiated once on the operand register.
- Round-robin selection stays inline as a function in palindrome_arbiter.

Test Plan:
(Each scenario uses NUM_REQ=4, DATA_WIDTH=8.)
1. Reset: hold resetn=0 with req_valid=4'hF -> req_ready=0, res_valid=0, res_id=0, res_pal=0, pal_count=0, busy=0.
2. Single request: req0 data 8'hA5, res_ready=1 -> req_ready=4'b0001 at T; res_valid at T+2 with res_id=0, res_pal=1. Repeat with 8'hA4 -> res_pal=0; pal_count=1 after both.
3. All requesters valid from reset: data 81,18,01,FF -> grant order 0,1,2,3; res_pal 1,1,0,1; back-to-back results every 2 cycles; pal_count=3.
4. Backpressure: res_ready=0 for 5 cycles while in RESULT -> res_valid stays 1, res_id/res_pal stable, req_ready=0. Raising res_ready with req1 valid -> handshake and req1 accepted on the same edge.
5. Fairness: force ptr=1, then hold req0 and req2 valid continuously -> grants 2,0,2,0.
6. Async reset mid-CHECK with operand 8'h3C -> outputs zero immediately with no clock edge; after release, no result for 3C appears; ptr=0.
